cnt_seq_monitor: RTL and testbench

Receiving-end checker for the 4-bit up/down counter stream produced by the counter top level. Samples the counter's output bus and direction select every valid cycle. Locks onto the incrementing or decrementing sequence and flags every out-of-sequence value. Counts errors and wrap-arounds for the bench and the board status LEDs.

---
 rtl/cnt_seq_monitor.sv | 119 +++++++++++
 tb/tb_cnt_seq_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cnt_seq_monitor.sv
// Purpose: locks onto an up/down counter stream and counts mismatches and wrap-arounds.
// Latency: one cycle from a sampling edge to registered LOCK/ERR/WRAP/count updates.
// Backpressure: none; VALID-qualified samples are always accepted. CNTMON_WRAPCNT_EN enables wrap logic.
module cnt_seq_monitor #(
    parameter int WIDTH      = 4,
    parameter int LOCK_LEN   = 3,
    parameter int MISS_LIMIT = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             VALID,
    input  logic             SEL_IN,
    input  logic [WIDTH-1:0] INDATA,
    output logic             LOCK,
    output logic             ERR,
    output logic [7:0]       ERR_CNT,
    output logic             WRAP,
    output logic [7:0]       WRAP_CNT
);

    localparam int MW  = $clog2(LOCK_LEN + 1);
    localparam int MSW = $clog2(MISS_LIMIT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] exp_val;
    logic             dir;
    logic [MW-1:0]    match_cnt;
    logic [MSW-1:0]   miss_cnt;

    logic [WIDTH-1:0] nxt_val;
    logic             hit;
    logic             dir_flip;
    logic [MW-1:0]    match_inc;
    logic [MSW-1:0]   miss_inc;

    assign nxt_val   = SEL_IN ? INDATA + WIDTH'(1) : INDATA - WIDTH'(1);
    assign hit       = (INDATA == exp_val);
    assign dir_flip  = (SEL_IN != dir);
    assign match_inc = match_cnt + MW'(1);
    assign miss_inc  = miss_cnt + MSW'(1);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= HUNT;
            exp_val   <= '0;
            dir       <= 1'b0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            LOCK      <= 1'b0;
            ERR       <= 1'b0;
            ERR_CNT   <= '0;
        end else begin
            ERR <= 1'b0;
            if (VALID) begin
                // Every valid sample re-seeds the expectation from itself.
                exp_val <= nxt_val;
                if (state == HUNT || dir_flip) begin
                    dir       <= SEL_IN;
                    match_cnt <= '0;
                    state     <= SYNC;
                    LOCK      <= 1'b0;
                end else if (state == SYNC) begin
                    if (hit) begin
                        if (match_inc == MW'(LOCK_LEN)) begin
                            state     <= LOCKED;
                            LOCK      <= 1'b1;
                            match_cnt <= '0;
                            miss_cnt  <= '0;
                        end else begin
                            match_cnt <= match_inc;
                        end
                    end else begin
                        match_cnt <= '0;
                    end
                end else begin
                    if (hit) begin
                        miss_cnt <= '0;
                    end else begin
                        ERR <= 1'b1;
                        if (ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
                        miss_cnt <= miss_inc;
                        if (miss_inc == MSW'(MISS_LIMIT)) begin
                            state <= HUNT;
                            LOCK  <= 1'b0;
                        end
                    end
                end
            end
        end
    end

`ifdef CNTMON_WRAPCNT_EN
    logic wrap_pt;
    assign wrap_pt = SEL_IN ? (INDATA == '0) : (INDATA == '1);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            WRAP     <= 1'b0;
            WRAP_CNT <= '0;
        end else begin
            WRAP <= 1'b0;
            if (VALID && state == LOCKED && !dir_flip && hit && wrap_pt) begin
                WRAP <= 1'b1;
                if (WRAP_CNT != 8'hFF) WRAP_CNT <= WRAP_CNT + 8'd1;
            end
        end
    end
`else
    assign WRAP     = 1'b0;
    assign WRAP_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_cnt_seq_monitor.sv
// Directed bench for cnt_seq_monitor with a per-cycle behavioural model plus literal checkpoints.
module tb_cnt_seq_monitor;
    localparam int W = 4;
    localparam int M = 16;
    localparam int LOCK_LEN = 3;
    localparam int MISS_LIMIT = 2;
`ifdef CNTMON_WRAPCNT_EN
    localparam int WRAP_ON = 1;
`else
    localparam int WRAP_ON = 0;
`endif

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         VALID = 1'b0;
    logic         SEL_IN = 1'b0;
    logic [W-1:0] INDATA = '0;
    logic         LOCK, ERR, WRAP;
    logic [7:0]   ERR_CNT, WRAP_CNT;

    cnt_seq_monitor #(.WIDTH(W), .LOCK_LEN(LOCK_LEN), .MISS_LIMIT(MISS_LIMIT)) dut (
        .CLK(CLK), .RESET(RESET), .VALID(VALID), .SEL_IN(SEL_IN), .INDATA(INDATA),
        .LOCK(LOCK), .ERR(ERR), .ERR_CNT(ERR_CNT), .WRAP(WRAP), .WRAP_CNT(WRAP_CNT)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // Model: phase 0 = hunting, 1 = syncing, 2 = locked.
    int m_phase = 0, m_exp = 0, m_dir = 0, m_run = 0, m_miss = 0;
    int m_lock = 0, m_err = 0, m_errcnt = 0, m_wrap = 0, m_wrapcnt = 0;

    function automatic int succ(int x, int up);
        return up != 0 ? (x + 1) % M : (x + M - 1) % M;
    endfunction

    task automatic mdl_reset();
        m_phase = 0; m_exp = 0; m_dir = 0; m_run = 0; m_miss = 0;
        m_lock = 0; m_err = 0; m_errcnt = 0; m_wrap = 0; m_wrapcnt = 0;
    endtask

    task automatic mdl_step(input int v, input int s, input int d);
        m_err = 0;
        m_wrap = 0;
        if (v != 0) begin
            if (m_phase == 0 || s != m_dir) begin
                m_dir = s; m_run = 0; m_phase = 1;
            end else if (m_phase == 1) begin
                if (d == m_exp) begin
                    m_run++;
                    if (m_run >= LOCK_LEN) begin m_phase = 2; m_miss = 0; end
                end else m_run = 0;
            end else if (d == m_exp) begin
                m_miss = 0;
                if (WRAP_ON != 0 && d == (s != 0 ? 0 : M - 1)) begin
                    m_wrap = 1;
                    m_wrapcnt = (m_wrapcnt < 255) ? m_wrapcnt + 1 : 255;
                end
            end else begin
                m_err = 1;
                m_errcnt = (m_errcnt < 255) ? m_errcnt + 1 : 255;
                m_miss++;
                if (m_miss >= MISS_LIMIT) m_phase = 0;
            end
            m_exp = succ(d, s);
            m_lock = (m_phase == 2) ? 1 : 0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input int expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    always @(posedge CLK) begin
        #1;
        chk("lock", {31'd0, LOCK}, m_lock);
        chk("err", {31'd0, ERR}, m_err);
        chk("err_cnt", {24'd0, ERR_CNT}, m_errcnt);
        chk("wrap", {31'd0, WRAP}, m_wrap);
        chk("wrap_cnt", {24'd0, WRAP_CNT}, m_wrapcnt);
    end

    task automatic step(input int v, input int s, input int d);
        VALID = (v != 0);
        SEL_IN = (s != 0);
        INDATA = W'(d);
        @(posedge CLK);
        mdl_step(v, s, d);
        @(negedge CLK);
    endtask

    task automatic lit_zero(input string tag);
        chk({tag, "_lock"}, {31'd0, LOCK}, 0);
        chk({tag, "_err"}, {31'd0, ERR}, 0);
        chk({tag, "_err_cnt"}, {24'd0, ERR_CNT}, 0);
        chk({tag, "_wrap"}, {31'd0, WRAP}, 0);
        chk({tag, "_wrap_cnt"}, {24'd0, WRAP_CNT}, 0);
    endtask

    initial begin
        int cur;
        #2;
        lit_zero("reset");
        @(negedge CLK);
        RESET = 1'b1;

        // Up-count 0..15 then 0..3
        for (int i = 0; i < 20; i++) begin
            step(1, 1, i % 16);
            if (i == 2) chk("up_lock_3rd", {31'd0, LOCK}, 0);
            if (i == 3) chk("up_lock_4th", {31'd0, LOCK}, 1);
            if (i == 15) chk("up_nowrap_15", {31'd0, WRAP}, 0);
            if (i == 16) chk("up_wrap_0", {31'd0, WRAP}, WRAP_ON);
        end
        chk("up_err_cnt", {24'd0, ERR_CNT}, 0);
        chk("up_wrap_cnt", {24'd0, WRAP_CNT}, WRAP_ON);

        // Down-count 5,4,3,2,1,0,15,14
        step(1, 0, 5);
        chk("dn_flip_lock", {31'd0, LOCK}, 0);
        step(1, 0, 4); step(1, 0, 3); step(1, 0, 2);
        chk("dn_lock_4th", {31'd0, LOCK}, 1);
        step(1, 0, 1); step(1, 0, 0);
        step(1, 0, 15);
        chk("dn_wrap_15", {31'd0, WRAP}, WRAP_ON);
        step(1, 0, 14);
        chk("dn_err_cnt", {24'd0, ERR_CNT}, 0);
        chk("dn_wrap_cnt", {24'd0, WRAP_CNT}, 2 * WRAP_ON);

        // Skip: relock up then 3,4,5,7,8,9
        for (int i = 0; i <= 5; i++) step(1, 1, i);
        step(1, 1, 7);
        chk("skip_err", {31'd0, ERR}, 1);
        chk("skip_err_cnt", {24'd0, ERR_CNT}, 1);
        step(1, 1, 8);
        chk("skip_lock_8", {31'd0, LOCK}, 1);
        chk("skip_err_8", {31'd0, ERR}, 0);
        step(1, 1, 9);

        // Loss of lock: stream to 6, then 9, 2 (back-to-back errors)
        for (int i = 10; i < 23; i++) step(1, 1, i % 16);
        step(1, 1, 9);
        chk("loss_err1", {31'd0, ERR}, 1);
        chk("loss_cnt1", {24'd0, ERR_CNT}, 2);
        chk("loss_lock1", {31'd0, LOCK}, 1);
        step(1, 1, 2);
        chk("loss_err2", {31'd0, ERR}, 1);
        chk("loss_cnt2", {24'd0, ERR_CNT}, 3);
        chk("loss_lock2", {31'd0, LOCK}, 0);

        // Direction flip from locked up-stream
        for (int i = 5; i <= 11; i++) step(1, 1, i);
        chk("flip_pre_lock", {31'd0, LOCK}, 1);
        step(1, 0, 10);
        chk("flip_lock", {31'd0, LOCK}, 0);
        chk("flip_err", {31'd0, ERR}, 0);
        step(1, 0, 9); step(1, 0, 8);
        chk("flip_lock_8", {31'd0, LOCK}, 0);
        step(1, 0, 7);
        chk("flip_lock_7", {31'd0, LOCK}, 1);
        chk("flip_err_cnt", {24'd0, ERR_CNT}, 3);

        // VALID gating
        for (int i = 0; i < 5; i++) step(0, 1, 12);
        chk("gate_lock", {31'd0, LOCK}, 1);
        chk("gate_err_cnt", {24'd0, ERR_CNT}, 3);
        step(1, 0, 6);
        chk("gate_match", {31'd0, ERR}, 0);
        step(1, 0, 2);
        chk("gate_err_pulse", {31'd0, ERR}, 1);
        step(0, 0, 2);
        chk("gate_err_drop", {31'd0, ERR}, 0);
        chk("gate_err_cnt2", {24'd0, ERR_CNT}, 4);
        step(1, 0, 1);
        chk("gate_relock", {31'd0, LOCK}, 1);

        // Saturation: alternating mismatch/match keeps lock while errors accumulate
        cur = 0;
        for (int i = 0; i < 300; i++) begin
            step(1, 0, (cur + M - 2) % M);
            step(1, 0, (cur + M - 3) % M);
            cur = (cur + M - 4) % M;
        end
        chk("sat_err_cnt", {24'd0, ERR_CNT}, 255);
        chk("sat_lock", {31'd0, LOCK}, 1);

        // Reset mid-stream, between edges
        VALID = 1'b1;
        RESET = 1'b0;
        #1;
        lit_zero("mid_reset");
        mdl_reset();
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        step(1, 1, 8);
        chk("post_rst_hunt", {31'd0, LOCK}, 0);
        step(1, 1, 9); step(1, 1, 10); step(1, 1, 11);
        chk("post_rst_lock", {31'd0, LOCK}, 1);
        chk("post_rst_errcnt", {24'd0, ERR_CNT}, 0);

        VALID = 1'b0;
        @(posedge CLK);
        mdl_step(0, 0, 0);
        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
